// File: rtl/tt_ctrl_pkg.sv
// Shared definitions for the ctrl-pad sequencer and decoder models.
package tt_ctrl_pkg;

  // Sequencer states, in the order the pulse train visits them.
  typedef enum logic [2:0] {
    StIdle,
    StEnaOff,
    StRst,
    StRstGap,
    StIncHi,
    StIncLo,
    StSettle,
    StFinish
  } tt_ctrl_seq_state_t;

  localparam int unsigned PulseCycDef  = 4;
  localparam int unsigned SettleCycDef = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_ctrl_seq_if.sv
// Request/status/pad bundle between a ctrl-pad sequencer and its user.
interface tt_ctrl_seq_if #(
  parameter int unsigned ADDR_W = 10
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ena;
  logic              busy;
  logic              done;
  logic              ctrl_sel_rst_n;
  logic              ctrl_sel_inc;
  logic              ctrl_ena;

  // Requester side (bring-up harness, self-test engine).
  modport master (
    output req_valid, req_addr, req_ena,
    input  req_ready, busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_addr, req_ena,
    output req_ready, busy, done, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena
  );

endinterface

// File: rtl/tt_ctrl_seq.sv
// Ctrl-pad transmit sequencer: disable, reset select counter, N increments, settle, re-enable.
module tt_ctrl_seq
  import tt_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned PULSE_CYC  = PulseCycDef,
  parameter int unsigned SETTLE_CYC = SettleCycDef
) (
  input  logic          clk,
  input  logic          rst,
  tt_ctrl_seq_if.slave  bus
);

  localparam int unsigned TmrMax = max_u(PULSE_CYC, SETTLE_CYC);
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  localparam logic [TmrW-1:0] PulseLoad  = TmrW'(PULSE_CYC - 1);
  localparam logic [TmrW-1:0] SettleLoad = TmrW'(SETTLE_CYC - 1);

  tt_ctrl_seq_state_t r_state, w_state_d;
  logic [TmrW-1:0]    r_tmr, w_tmr_d;
  logic [ADDR_W-1:0]  r_cnt, w_cnt_d;
  logic               r_en_q, w_en_q_d;

  // Output flops: every pad/status output comes straight from one of these.
  logic r_req_ready, w_req_ready_d;
  logic r_busy, w_busy_d;
  logic r_done, w_done_d;
  logic r_sel_rst_n, w_sel_rst_n_d;
  logic r_sel_inc, w_sel_inc_d;
  logic r_ena, w_ena_d;

  logic w_xfer;
  logic w_tmr_zero;

  // r_req_ready is only ever high while r_state is StIdle.
  assign w_xfer     = bus.req_valid & r_req_ready;
  assign w_tmr_zero = (r_tmr == '0);

  // State, timer and pulse counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_tmr   <= '0;
      r_cnt   <= '0;
      r_en_q  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_tmr   <= w_tmr_d;
      r_cnt   <= w_cnt_d;
      r_en_q  <= w_en_q_d;
    end
  end

  // Next-state, timer reload and increment bookkeeping.
  always_comb begin
    w_state_d = r_state;
    w_tmr_d   = r_tmr;
    w_cnt_d   = r_cnt;
    w_en_q_d  = r_en_q;

    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_state_d = StEnaOff;
          w_cnt_d   = bus.req_addr;
          w_en_q_d  = bus.req_ena;
        end
      end
      StEnaOff: if (w_tmr_zero) w_state_d = StRst;
      StRst:    if (w_tmr_zero) w_state_d = StRstGap;
      StRstGap: begin
        if (w_tmr_zero) w_state_d = (r_cnt != '0) ? StIncHi : StSettle;
      end
      StIncHi:  if (w_tmr_zero) w_state_d = StIncLo;
      StIncLo: begin
        // One pulse completes at the end of its low phase; cnt is never zero here.
        if (w_tmr_zero) begin
          w_cnt_d   = r_cnt - 1'b1;
          w_state_d = (w_cnt_d != '0) ? StIncHi : StSettle;
        end
      end
      StSettle: if (w_tmr_zero) w_state_d = StFinish;
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase

    // Single down-counter, reloaded on every state change (including IncLo -> IncHi).
    if (w_state_d != r_state) begin
      unique case (w_state_d)
        StEnaOff, StSettle:                  w_tmr_d = SettleLoad;
        StRst, StRstGap, StIncHi, StIncLo:   w_tmr_d = PulseLoad;
        default:                             w_tmr_d = '0;
      endcase
    end else if (!w_tmr_zero) begin
      w_tmr_d = r_tmr - 1'b1;
    end
  end

  // Output values for the state being entered, so the flops line up with r_state.
  always_comb begin
    w_req_ready_d = (w_state_d == StIdle);
    w_busy_d      = (w_state_d != StIdle);
    w_done_d      = (w_state_d == StFinish);
    w_sel_rst_n_d = (w_state_d != StRst);
    w_sel_inc_d   = (w_state_d == StIncHi);
    unique case (w_state_d)
      StIdle:   w_ena_d = r_ena;
      StFinish: w_ena_d = r_en_q;
      default:  w_ena_d = 1'b0;
    endcase
  end

  // Output registers; async reset drives pads to their safe values immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sel_rst_n <= 1'b0;
      r_sel_inc   <= 1'b0;
      r_ena       <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_sel_rst_n <= w_sel_rst_n_d;
      r_sel_inc   <= w_sel_inc_d;
      r_ena       <= w_ena_d;
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.ctrl_sel_rst_n = r_sel_rst_n;
  assign bus.ctrl_sel_inc   = r_sel_inc;
  assign bus.ctrl_ena       = r_ena;

endmodule
